// File: rtl/mfcc_melbank_pkg.sv
// mfcc_melbank_pkg: shared widths, FSM state type and accumulator sizing for the mel filter engine
package mfcc_melbank_pkg;

    localparam int DEF_ADDR_WIDTH   = 9;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_PWR_WIDTH    = 32;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        OUT
    } state_t;

    // Wide enough that a full frame of max power times max weight never overflows
    function automatic int acc_width(input int pwr_w, input int weight_w, input int addr_w);
        return pwr_w + weight_w + addr_w;
    endfunction

endpackage

// File: rtl/mfcc_melbank_mac.sv
// mfcc_melbank_mac: ROM-latency delay line, registered multiplier and clearable accumulator
module mfcc_melbank_mac
    import mfcc_melbank_pkg::*;
#(
    parameter int PWR_WIDTH    = DEF_PWR_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int ROM_LATENCY  = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  clr_i,
    input  logic                                                  valid_i,
    input  logic                                                  last_i,
    input  logic [PWR_WIDTH-1:0]                                  pwr_i,
    input  logic [WEIGHT_WIDTH-1:0]                               weight_i,
    output logic [acc_width(PWR_WIDTH, WEIGHT_WIDTH, ADDR_WIDTH)-1:0] acc_o,
    output logic                                                  done_o
);

    localparam int PROD_W = PWR_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_W  = acc_width(PWR_WIDTH, WEIGHT_WIDTH, ADDR_WIDTH);

    logic [PWR_WIDTH-1:0]   pwr_q [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] vld_q;
    logic [ROM_LATENCY-1:0] lst_q;
    logic [PROD_W-1:0]      prod_q;
    logic                   prod_vld_q;
    logic                   prod_lst_q;
    logic [ACC_W-1:0]       acc_q;
    logic                   done_q;

    // Hold each accepted bin until its weight comes back from the ROM
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) pwr_q[i] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            lst_q[0] <= last_i;
            pwr_q[0] <= pwr_i;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
                pwr_q[i] <= pwr_q[i-1];
            end
        end
    end

    // Multiply aligned bin by weight, then fold into the frame sum; done marks the last product landing
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            prod_lst_q <= 1'b0;
            acc_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            prod_q     <= PROD_W'(pwr_q[ROM_LATENCY-1]) * PROD_W'(weight_i);
            prod_vld_q <= vld_q[ROM_LATENCY-1];
            prod_lst_q <= vld_q[ROM_LATENCY-1] & lst_q[ROM_LATENCY-1];
            acc_q      <= clr_i ? '0 : prod_vld_q ? acc_q + ACC_W'(prod_q) : acc_q;
            done_q     <= prod_vld_q & prod_lst_q;
        end
    end

    assign acc_o  = acc_q;
    assign done_o = done_q;

endmodule

// File: rtl/mfcc_melbank_filter.sv
// mfcc_melbank_filter: frame-level mel filter energy engine; MELBANK_SATURATE_EN clamps the output instead of truncating
module mfcc_melbank_filter
    import mfcc_melbank_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int PWR_WIDTH    = DEF_PWR_WIDTH,
    parameter int OUT_WIDTH    = 32,
    parameter int ROM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwr_valid,
    output logic                    pwr_ready,
    input  logic [PWR_WIDTH-1:0]    pwr_data,
    input  logic                    pwr_last,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [WEIGHT_WIDTH-1:0] rom_data,
    output logic                    energy_valid,
    input  logic                    energy_ready,
    output logic [OUT_WIDTH-1:0]    energy_data,
    output logic                    len_err
);

    localparam int ACC_W = acc_width(PWR_WIDTH, WEIGHT_WIDTH, ADDR_WIDTH);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  pwr_ready_q;
    logic                  energy_valid_q;
    logic [OUT_WIDTH-1:0]  energy_q;
    logic                  len_err_q;
    logic                  accept;
    logic                  handshake;
    logic [ACC_W-1:0]      acc;
    logic                  mac_done;
    logic [OUT_WIDTH-1:0]  energy_fit;

    assign accept    = pwr_valid & pwr_ready_q;
    assign handshake = energy_valid_q & energy_ready;

    mfcc_melbank_mac #(
        .PWR_WIDTH   (PWR_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ROM_LATENCY (ROM_LATENCY)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (handshake),
        .valid_i (accept),
        .last_i  (pwr_last),
        .pwr_i   (pwr_data),
        .weight_i(rom_data),
        .acc_o   (acc),
        .done_o  (mac_done)
    );

`ifdef MELBANK_SATURATE_EN
    logic [ACC_W+OUT_WIDTH-1:0] wide;
    assign wide       = {{OUT_WIDTH{1'b0}}, acc >> WEIGHT_WIDTH};
    assign energy_fit = (|(wide >> OUT_WIDTH)) ? '1 : wide[OUT_WIDTH-1:0];
`else
    assign energy_fit = OUT_WIDTH'(acc >> WEIGHT_WIDTH);
`endif

    // Frame FSM: stream bins, wait for the pipeline to drain, then present the energy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            pwr_ready_q    <= 1'b0;
            energy_valid_q <= 1'b0;
            energy_q       <= '0;
            len_err_q      <= 1'b0;
        end else begin
            len_err_q <= accept & ~pwr_last & (&cnt_q);
            case (state_q)
                RUN: begin
                    pwr_ready_q <= ~(accept & pwr_last);
                    if (accept) begin
                        cnt_q <= pwr_last ? '0 : cnt_q + 1'b1;
                        if (pwr_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mac_done) begin
                        state_q        <= OUT;
                        energy_valid_q <= 1'b1;
                        energy_q       <= energy_fit;
                    end
                end
                OUT: begin
                    if (energy_ready) begin
                        state_q        <= RUN;
                        energy_valid_q <= 1'b0;
                        pwr_ready_q    <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign pwr_ready    = pwr_ready_q;
    assign rom_addr     = cnt_q;
    assign energy_valid = energy_valid_q;
    assign energy_data  = energy_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_mfcc_melbank_filter.sv
// tb_mfcc_melbank_filter: three engines (latency 1, latency 2, 16-bit output) fed in lockstep against a frame-sum model
module tb_mfcc_melbank_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwr_valid;
    logic        pwr_last;
    logic [31:0] pwr_data;
    logic [2:0]  rdy, ev, er, lerr;
    logic [8:0]  addr_a, addr_b, addr_c;
    logic [7:0]  rom_a, rom_b1, rom_b, rom_c;
    logic [31:0] ed_a, ed_b;
    logic [15:0] ed_c;

    logic [63:0] acc_m;
    int          idx_m, exp_lerr, last_cyc;
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    int          lerr_cnt [3] = '{0, 0, 0};
    int          rise_cnt [3] = '{0, 0, 0};
    logic [2:0]  ev_prev = 3'b000;
    logic [31:0] dat [512];
    logic [31:0] e_last [3];

    always #5 clk = ~clk;

    mfcc_melbank_filter #(.OUT_WIDTH(32), .ROM_LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .pwr_valid(pwr_valid), .pwr_ready(rdy[0]), .pwr_data(pwr_data),
        .pwr_last(pwr_last), .rom_addr(addr_a), .rom_data(rom_a), .energy_valid(ev[0]),
        .energy_ready(er[0]), .energy_data(ed_a), .len_err(lerr[0]));

    mfcc_melbank_filter #(.OUT_WIDTH(32), .ROM_LATENCY(2)) u_b (
        .clk(clk), .rst(rst), .pwr_valid(pwr_valid), .pwr_ready(rdy[1]), .pwr_data(pwr_data),
        .pwr_last(pwr_last), .rom_addr(addr_b), .rom_data(rom_b), .energy_valid(ev[1]),
        .energy_ready(er[1]), .energy_data(ed_b), .len_err(lerr[1]));

    mfcc_melbank_filter #(.OUT_WIDTH(16), .ROM_LATENCY(1)) u_c (
        .clk(clk), .rst(rst), .pwr_valid(pwr_valid), .pwr_ready(rdy[2]), .pwr_data(pwr_data),
        .pwr_last(pwr_last), .rom_addr(addr_c), .rom_data(rom_c), .energy_valid(ev[2]),
        .energy_ready(er[2]), .energy_data(ed_c), .len_err(lerr[2]));

    // Weight ROMs holding weight = addr[7:0], with one or two register stages
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rom_a  <= 8'(addr_a);
        rom_b1 <= 8'(addr_b);
        rom_b  <= rom_b1;
        rom_c  <= 8'(addr_c);
    end

    // Count len_err pulses and energy_valid rising edges per engine
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (lerr[k]) lerr_cnt[k]++;
            if (ev[k] && !ev_prev[k]) rise_cnt[k]++;
        end
        ev_prev = ev;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fit(input logic [63:0] sh, input int w);
        logic [63:0] mx = (64'd1 << w) - 64'd1;
`ifdef MELBANK_SATURATE_EN
        return sh > mx ? mx : sh;
`else
        return sh & mx;
`endif
    endfunction

    function automatic logic [31:0] energy_of(input int k);
        return k == 0 ? ed_a : k == 1 ? ed_b : {16'd0, ed_c};
    endfunction

    task automatic push(input logic [31:0] d, input bit last);
        int n = 0;
        while (rdy != 3'b111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", {61'd0, rdy}, 64'd7);
        pwr_valid = 1'b1;
        pwr_data  = d;
        pwr_last  = last;
        acc_m += 64'(d) * 64'(idx_m % 256);
        if (idx_m == 511 && !last) exp_lerr++;
        idx_m = last ? 0 : (idx_m + 1) % 512;
        @(negedge clk);
        last_cyc  = cyc;
        pwr_valid = 1'b0;
        pwr_last  = 1'b0;
    endtask

    task automatic send_dat(input int n, input int bub, input bit last);
        for (int i = 0; i < n; i++) begin
            if (bub > 0 && $urandom_range(99) < bub) repeat ($urandom_range(1, 3)) @(negedge clk);
            push(dat[i % 512], last && i == n - 1);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 512; i++) dat[i] = v;
    endtask

    task automatic finish_frame(input int hold);
        int lat [3] = '{-1, -1, -1};
        bit stable = 1'b1;
        bit quiet = 1'b1;
        for (int n = 0; n < 50 && ev != 3'b111; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (ev[k] && lat[k] < 0) lat[k] = cyc - last_cyc;
        end
        check("valid_timeout", {61'd0, ev}, 64'd7);
        for (int k = 0; k < 3; k++) begin
            e_last[k] = energy_of(k);
            check($sformatf("energy[%0d]", k), {32'd0, e_last[k]}, fit(acc_m >> 8, k == 2 ? 16 : 32));
            check($sformatf("latency[%0d]", k), 64'(lat[k]), k == 1 ? 64'd4 : 64'd3);
        end
        check("ready_in_out", {61'd0, rdy}, 64'd0);
        repeat (hold) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (energy_of(k) !== e_last[k] || !ev[k]) stable = 1'b0;
            if (rdy != 3'b000) quiet = 1'b0;
        end
        if (hold > 0) begin
            check("hold_stable", {63'd0, stable}, 64'd1);
            check("hold_ready_low", {63'd0, quiet}, 64'd1);
        end
        er = 3'b111;
        @(negedge clk);
        er = 3'b000;
        check("valid_after_hs", {61'd0, ev}, 64'd0);
        check("ready_after_hs", {61'd0, rdy}, 64'd7);
        acc_m = 0;
        idx_m = 0;
    endtask

    initial begin
        logic [31:0] gapless_e;
        int          r0;
        rst = 1'b1; pwr_valid = 1'b0; pwr_last = 1'b0; pwr_data = '0; er = 3'b000;
        acc_m = 0; idx_m = 0; exp_lerr = 0; last_cyc = 0;
        repeat (2) @(negedge clk);
        check("rst_pwr_ready", {61'd0, rdy}, 64'd0);
        check("rst_energy_valid", {61'd0, ev}, 64'd0);
        check("rst_rom_addr", {55'd0, addr_a}, 64'd0);
        check("rst_energy_data", {32'd0, ed_a}, 64'd0);
        check("rst_len_err", {61'd0, lerr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {61'd0, rdy}, 64'd7);

        fill(32'd1);        send_dat(512, 0, 1'b1); finish_frame(0);
        fill(32'd256);      send_dat(512, 0, 1'b1); finish_frame(0);
        fill(32'd1 << 20);  send_dat(512, 0, 1'b1); finish_frame(0);
        for (int k = 0; k < 3; k++) check($sformatf("no_len_err[%0d]", k), 64'(lerr_cnt[k]), 64'(exp_lerr));

        fill(32'd1);
        send_dat(600, 0, 1'b0);
        push(32'd1, 1'b1);
        finish_frame(0);
        for (int k = 0; k < 3; k++) check($sformatf("len_err_cnt[%0d]", k), 64'(lerr_cnt[k]), 64'(exp_lerr));

        for (int i = 0; i < 512; i++) dat[i] = $urandom;
        send_dat(512, 0, 1'b1);  finish_frame(0);
        gapless_e = e_last[0];
        send_dat(512, 30, 1'b1); finish_frame(20);
        check("bubble_vs_gapless", {32'd0, e_last[0]}, {32'd0, gapless_e});

        dat[0] = $urandom; send_dat(1, 0, 1'b1); finish_frame(0);
        for (int i = 0; i < 3; i++) dat[i] = $urandom;
        send_dat(3, 20, 1'b1); finish_frame(2);
        for (int i = 0; i < 512; i++) dat[i] = $urandom_range(0, 65535);
        send_dat($urandom_range(2, 60), 40, 1'b1); finish_frame(5);

        fill(32'd1);
        send_dat(100, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_rst_ready", {61'd0, rdy}, 64'd0);
        rst = 1'b0;
        acc_m = 0; idx_m = 0;
        r0 = rise_cnt[0];
        send_dat(512, 0, 1'b1); finish_frame(0);
        @(negedge clk);
        check("single_emit", 64'(rise_cnt[0] - r0), 64'd1);

        send_dat(7, 0, 1'b1);
        for (int n = 0; n < 50 && ev != 3'b111; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("out_rst_valid", {61'd0, ev}, 64'd0);
        acc_m = 0; idx_m = 0;
        send_dat(512, 10, 1'b1); finish_frame(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
